cmp_select_pipe: RTL and testbench

Parametrised, handshaked successor to the fixed 64→32 compare/select datapath. It computes two sums and a difference, selects by compare result, applies compare-gated variable shifts, and narrows to the output width. It adds a two-stage valid/ready pipeline with backpressure, a signed/unsigned mode, a variable shift amount and a transfer counter. It sits between an operand producer and a result consumer in the arithmetic datapath.

---
 rtl/cmp_select_pipe_if.sv | 39 +++
 rtl/cmp_select_pipe.sv | 137 +++++++++++++
 tb/tb_cmp_select_pipe.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_select_pipe_if.sv
// Handshake bundle for cmp_select_pipe.
//   master: operand producer / result consumer side (drives operands and out_ready)
//   slave : the compare/select block (drives in_ready, results and transfer count)
// Signals:
//   in_valid/in_ready        operand handshake
//   a, b, c (DATAW)          operands
//   sh (SHW), sgn            shift amount, signed mode
//   out_valid/out_ready      result handshake
//   x, z (OUTW)              results
//   cnt (CNTW)               completed output transfers
interface cmp_select_pipe_if #(
  parameter int unsigned DATAW = 64,
  parameter int unsigned OUTW  = 32,
  parameter int unsigned SHW   = 6,
  parameter int unsigned CNTW  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] a;
  logic [DATAW-1:0] b;
  logic [DATAW-1:0] c;
  logic [SHW-1:0]   sh;
  logic             sgn;
  logic             out_valid;
  logic             out_ready;
  logic [OUTW-1:0]  x;
  logic [OUTW-1:0]  z;
  logic [CNTW-1:0]  cnt;

  modport master (
    output in_valid, a, b, c, sh, sgn, out_ready,
    input  in_ready, out_valid, x, z, cnt
  );

  modport slave (
    input  in_valid, a, b, c, sh, sgn, out_ready,
    output in_ready, out_valid, x, z, cnt
  );
endinterface

// File: rtl/cmp_select_pipe.sv
// Two-stage valid/ready compare/select datapath.
// Stage 1 forms d=a+b, e=a+c, f=a-b, compares d against e (signed when sgn=1) and
// registers the selected g/h together with the compare flags. Stage 2 applies the
// compare-gated shifts and narrows to OUTW bits.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cmp_select_pipe_if.slave (operand/result handshakes, results, transfer count)
// Build option:
//   SATURATE_EN  when defined, x/z saturate to OUTW bits (unsigned or signed range
//                following sgn) instead of truncating; requires OUTW < DATAW.
module cmp_select_pipe #(
  parameter int unsigned DATAW = 64,
  parameter int unsigned OUTW  = 32,
  parameter int unsigned SHW   = 6,
  parameter int unsigned CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_select_pipe_if.slave  bus
);

  // Stage 1 state
  logic             v1_q;
  logic [DATAW-1:0] g_q, h_q;
  logic             lt_q, eq_q, sgn_q;
  logic [SHW-1:0]   sh_q;

  // Stage 2 state
  logic             v2_q;
  logic [OUTW-1:0]  x_q, z_q;
  logic [CNTW-1:0]  cnt_q;

  logic             s2_load;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;

  // Stage 1 combinational datapath
  logic [DATAW-1:0] d, e, f, g_d, h_d;
  logic             lt_d, eq_d;

  // Stage 2 combinational datapath
  logic [DATAW-1:0] xw, zw;
  logic [OUTW-1:0]  x_d, z_d;

  // in_ready depends combinationally on out_ready through s2_load.
  assign s2_load  = v1_q & (~v2_q | bus.out_ready);
  assign in_ready = ~v1_q | s2_load;
  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = v2_q & bus.out_ready;

  always_comb begin
    d    = bus.a + bus.b;
    e    = bus.a + bus.c;
    f    = bus.a - bus.b;
    lt_d = bus.sgn ? ($signed(d) < $signed(e)) : (d < e);
    eq_d = (d == e);
    g_d  = lt_d ? d : e;
    h_d  = eq_d ? g_d : f;
  end

  always_comb begin
    // SV shift semantics already give 0 (or sign fill for >>>) when sh >= DATAW.
    xw = lt_q ? (h_q << sh_q) : h_q;
    zw = g_q;
    if (eq_q) begin
      if (sgn_q) zw = $unsigned($signed(g_q) >>> sh_q);
      else       zw = g_q >> sh_q;
    end
`ifdef SATURATE_EN
    x_d = OUTW'(xw);
    z_d = OUTW'(zw);
    if (sgn_q) begin
      // Out of range when the bits above the OUTW-1 sign position disagree with it.
      if (xw[DATAW-1:OUTW-1] != '0 && xw[DATAW-1:OUTW-1] != '1)
        x_d = xw[DATAW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
      if (zw[DATAW-1:OUTW-1] != '0 && zw[DATAW-1:OUTW-1] != '1)
        z_d = zw[DATAW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
    end else begin
      if (|xw[DATAW-1:OUTW]) x_d = '1;
      if (|zw[DATAW-1:OUTW]) z_d = '1;
    end
`else
    x_d = OUTW'(xw);
    z_d = OUTW'(zw);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      g_q   <= '0;
      h_q   <= '0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      sh_q  <= '0;
      sgn_q <= 1'b0;
    end else begin
      // Stage 1 empties or refills whenever it can hand on (or is empty).
      if (in_ready) v1_q <= bus.in_valid;
      if (in_xfer) begin
        g_q   <= g_d;
        h_q   <= h_d;
        lt_q  <= lt_d;
        eq_q  <= eq_d;
        sh_q  <= bus.sh;
        sgn_q <= bus.sgn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      x_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (s2_load) begin
        v2_q <= 1'b1;
        x_q  <= x_d;
        z_q  <= z_d;
      end else if (bus.out_ready) begin
        v2_q <= 1'b0;
      end
      if (out_xfer) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v2_q;
  assign bus.x         = x_q;
  assign bus.z         = z_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_cmp_select_pipe.sv
// Directed self-checking bench for cmp_select_pipe.
module tb_cmp_select_pipe;
  localparam int unsigned DW = 64;
  localparam int unsigned OW = 32;
  localparam int unsigned SW = 6;
  localparam int unsigned CW = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cmp_select_pipe_if #(.DATAW(DW), .OUTW(OW), .SHW(SW), .CNTW(CW)) bus ();

  cmp_select_pipe #(.DATAW(DW), .OUTW(OW), .SHW(SW), .CNTW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set into an empty pipe with out_ready=1 and capture the
  // out_valid waveform around it. Called at posedge+1.
  task automatic drive_one(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [SW-1:0] sh,
                           input logic sgn, output logic v_early, output logic v_on,
                           output logic v_after, output logic [OW-1:0] ox,
                           output logic [OW-1:0] oz);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = a; bus.b = b; bus.c = c; bus.sh = sh; bus.sgn = sgn;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    v_early = bus.out_valid;
    @(posedge clk); #1;
    v_on = bus.out_valid;
    ox   = bus.x;
    oz   = bus.z;
    @(posedge clk); #1;
    v_after = bus.out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.sh = '0; bus.sgn = 1'b0;
    #12;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.x !== '0 || bus.z !== '0 || bus.cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b x=%h z=%h cnt=%0d, required 0 0 0 0",
               bus.out_valid, bus.x, bus.z, bus.cnt);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic ve, vo, va; logic [OW-1:0] ox, oz;
    drive_one(64'd5, 64'd3, 64'd1, 6'd1, 1'b0, ve, vo, va, ox, oz);
    n_checks++;
    if (ve !== 1'b0 || vo !== 1'b1 || va !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid seq %b%b%b, required 010", ve, vo, va);
    end
    n_checks++;
    if (ox !== 32'd2 || oz !== 32'd6) begin
      n_fail++;
      $display("FAIL basic_result: x=%0d z=%0d, required x=2 z=6", ox, oz);
    end
    n_checks++;
    if (bus.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_cnt: got %0d, required 1", bus.cnt);
    end
  endtask

  task automatic test_lt_eq;
    logic ve, vo, va; logic [OW-1:0] ox, oz;
    drive_one(64'd4, 64'd1, 64'd9, 6'd2, 1'b0, ve, vo, va, ox, oz);
    n_checks++;
    if (vo !== 1'b1 || ox !== 32'd12 || oz !== 32'd5) begin
      n_fail++;
      $display("FAIL lt_path: v=%b x=%0d z=%0d, required v=1 x=12 z=5", vo, ox, oz);
    end
    drive_one(64'd1, 64'd2, 64'd2, 6'd1, 1'b0, ve, vo, va, ox, oz);
    n_checks++;
    if (vo !== 1'b1 || ox !== 32'd3 || oz !== 32'd1) begin
      n_fail++;
      $display("FAIL eq_path: v=%b x=%0d z=%0d, required v=1 x=3 z=1", vo, ox, oz);
    end
    n_checks++;
    if (bus.cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL lt_eq_cnt: got %0d, required 3", bus.cnt);
    end
  endtask

  task automatic test_sign_mode;
    logic ve, vo, va; logic [OW-1:0] ox, oz;
    drive_one({DW{1'b1}}, 64'd0, 64'd1, 6'd1, 1'b1, ve, vo, va, ox, oz);
    n_checks++;
    if (ox !== 32'hFFFF_FFFE || oz !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL signed_ones: x=%h z=%h, required fffffffe ffffffff", ox, oz);
    end
    drive_one({DW{1'b1}}, 64'd0, 64'd1, 6'd1, 1'b0, ve, vo, va, ox, oz);
    n_checks++;
    if (ox !== 32'hFFFF_FFFF || oz !== 32'h0) begin
      n_fail++;
      $display("FAIL unsigned_ones: x=%h z=%h, required ffffffff 00000000", ox, oz);
    end
  endtask

  task automatic test_narrow;
    logic ve, vo, va; logic [OW-1:0] ox, oz, ex;
`ifdef SATURATE_EN
    ex = 32'hFFFF_FFFF;
`else
    ex = 32'h0;
`endif
    drive_one(64'h100_0000_0000, 64'd0, 64'h100_0000_0000, 6'd1, 1'b0, ve, vo, va, ox, oz);
    n_checks++;
    if (ox !== ex || oz !== ex) begin
      n_fail++;
      $display("FAIL narrow_wide: x=%h z=%h, required both %h", ox, oz, ex);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] va_t [8];
    logic [DW-1:0] vb_t [8];
    logic [DW-1:0] vc_t [8];
    logic [SW-1:0] vs_t [8];
    logic [OW-1:0] ex_t [8];
    logic [OW-1:0] ez_t [8];
    int sent, got, cyc;
    logic stalled, saw_full, acc, dlv;
    logic [OW-1:0] px, pz;
    va_t = '{64'd1, 64'd2, 64'd5, 64'd4, 64'd1, 64'd7, 64'd10, 64'd3};
    vb_t = '{64'd0, 64'd0, 64'd3, 64'd1, 64'd2, 64'd0, 64'd4,  64'd3};
    vc_t = '{64'd1, 64'd1, 64'd1, 64'd9, 64'd2, 64'd1, 64'd1,  64'd3};
    vs_t = '{6'd1,  6'd2,  6'd1,  6'd2,  6'd1,  6'd3,  6'd1,   6'd2};
    ex_t = '{32'd2, 32'd8, 32'd2, 32'd12, 32'd3, 32'd56, 32'd6, 32'd6};
    ez_t = '{32'd1, 32'd2, 32'd6, 32'd5,  32'd1, 32'd7,  32'd11, 32'd1};
    // Fresh reset so the transfer count starts from zero.
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; saw_full = 1'b0; px = '0; pz = '0;
    while (got < 8 && cyc < 200) begin
      bus.in_valid = (sent < 8);
      if (sent < 8) begin
        bus.a = va_t[sent]; bus.b = vb_t[sent]; bus.c = vc_t[sent];
        bus.sh = vs_t[sent]; bus.sgn = 1'b0;
      end
      bus.out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== (((sent - got) < 2) || bus.out_ready)) begin
        n_fail++;
        $display("FAIL bp_in_ready: cyc %0d pending %0d got %b", cyc, sent - got, bus.in_ready);
      end
      if ((sent - got) == 2 && !bus.out_ready) saw_full = 1'b1;
      if (stalled) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.x !== px || bus.z !== pz) begin
          n_fail++;
          $display("FAIL bp_hold: v=%b x=%h z=%h, required 1 %h %h",
                   bus.out_valid, bus.x, bus.z, px, pz);
        end
      end
      acc = bus.in_valid & bus.in_ready;
      dlv = bus.out_valid & bus.out_ready;
      if (dlv) begin
        n_checks++;
        if (bus.x !== ex_t[got] || bus.z !== ez_t[got]) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: x=%0d z=%0d, required x=%0d z=%0d",
                   got, bus.x, bus.z, ex_t[got], ez_t[got]);
        end
        got++;
      end
      stalled = bus.out_valid & ~bus.out_ready;
      px = bus.x; pz = bus.z;
      if (acc) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL bp_timeout: delivered %0d, required 8", got);
    end
    n_checks++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL bp_fill: both stages never full under stall, required full");
    end
    n_checks++;
    if (bus.cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL bp_cnt: got %0d, required 8", bus.cnt);
    end
  endtask

  task automatic test_reset_midflight;
    logic ve, vo, va; logic [OW-1:0] ox, oz;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 64'd7; bus.b = 64'd0; bus.c = 64'd1; bus.sh = 6'd3; bus.sgn = 1'b0;
    @(posedge clk); #1;
    bus.a = 64'd10; bus.b = 64'd4; bus.c = 64'd1; bus.sh = 6'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_full: out_valid=%b in_ready=%b, required 1 0",
               bus.out_valid, bus.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.cnt !== '0 || bus.x !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_clear: v=%b cnt=%0d x=%h in_ready=%b, required 0 0 0 1",
               bus.out_valid, bus.cnt, bus.x, bus.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive_one(64'd4, 64'd1, 64'd9, 6'd2, 1'b0, ve, vo, va, ox, oz);
    n_checks++;
    if (ve !== 1'b0 || vo !== 1'b1 || va !== 1'b0 || ox !== 32'd12 || oz !== 32'd5) begin
      n_fail++;
      $display("FAIL midrst_after: v seq %b%b%b x=%0d z=%0d, required 010 x=12 z=5",
               ve, vo, va, ox, oz);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_stale: out_valid=%b cnt=%0d, required 0 1", bus.out_valid, bus.cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_lt_eq();
    test_sign_mode();
    test_narrow();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
